// File: rtl/riscv_core_pc_gen.sv
// Fetch-side PC generator: issues one instruction fetch at a time, holds the
// returned instruction for decode, and follows redirects with priority.
module riscv_core_pc_gen #(
    parameter int unsigned       XLEN         = 64,
    parameter logic [XLEN-1:0]   RESET_VECTOR = 64'h0000_0000_8000_0000
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_pcgen_redirect,
    input  logic [XLEN-1:0] i_pcgen_redirect_pc,
    input  logic            i_pcgen_stall,
    output logic            o_pcgen_req_valid,
    output logic [XLEN-1:0] o_pcgen_req_addr,
    input  logic            i_pcgen_req_ready,
    input  logic            i_pcgen_rsp_valid,
    input  logic [31:0]     i_pcgen_rsp_instr,
    output logic            o_pcgen_instr_valid,
    output logic [31:0]     o_pcgen_instr,
    output logic [XLEN-1:0] o_pcgen_instr_pc,
    output logic            o_pcgen_is_compressed
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } state_t;

    state_t          state, state_n;
    logic [XLEN-1:0] pc, pc_n;
    logic            instr_valid, instr_valid_n;
    logic [31:0]     instr, instr_n;
    logic [XLEN-1:0] instr_pc, instr_pc_n;
    logic            is_c, is_c_n;

    logic [XLEN-1:0] target;
    logic            rsp_is_c;
    logic [XLEN-1:0] step;

    // Redirect targets are forced to halfword alignment.
    assign target   = {i_pcgen_redirect_pc[XLEN-1:1], 1'b0};
    assign rsp_is_c = (i_pcgen_rsp_instr[1:0] != 2'b11);
    assign step     = rsp_is_c ? XLEN'(2) : XLEN'(4);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= S_REQ;
            pc          <= RESET_VECTOR;
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
            is_c        <= 1'b0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            instr_valid <= instr_valid_n;
            instr       <= instr_n;
            instr_pc    <= instr_pc_n;
            is_c        <= is_c_n;
        end
    end

    always_comb begin
        state_n           = state;
        pc_n              = pc;
        instr_valid_n     = instr_valid;
        instr_n           = instr;
        instr_pc_n        = instr_pc;
        is_c_n            = is_c;
        o_pcgen_req_valid = 1'b0;

        unique case (state)
            S_REQ: begin
                o_pcgen_req_valid = 1'b1;
                if (i_pcgen_redirect) begin
                    // An already-accepted request must have its response dropped.
                    pc_n    = target;
                    state_n = i_pcgen_req_ready ? S_DROP : S_REQ;
                end else if (i_pcgen_req_ready) begin
                    state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_pcgen_redirect) begin
                    pc_n    = target;
                    state_n = i_pcgen_rsp_valid ? S_REQ : S_DROP;
                end else if (i_pcgen_rsp_valid) begin
                    instr_valid_n = 1'b1;
                    instr_n       = i_pcgen_rsp_instr;
                    instr_pc_n    = pc;
                    is_c_n        = rsp_is_c;
                    pc_n          = pc + step;
                    state_n       = S_HOLD;
                end
            end
            S_HOLD: begin
                if (i_pcgen_redirect) begin
                    instr_valid_n = 1'b0;
                    pc_n          = target;
                    state_n       = S_REQ;
                end else if (!i_pcgen_stall) begin
                    instr_valid_n = 1'b0;
                    state_n       = S_REQ;
                end
            end
            S_DROP: begin
                if (i_pcgen_redirect) begin
                    pc_n = target;
                end else if (i_pcgen_rsp_valid) begin
                    state_n = S_REQ;
                end
            end
            default: state_n = S_REQ;
        endcase
    end

    assign o_pcgen_req_addr      = pc;
    assign o_pcgen_instr_valid   = instr_valid;
    assign o_pcgen_instr         = instr;
    assign o_pcgen_instr_pc      = instr_pc;
    assign o_pcgen_is_compressed = is_c;

endmodule
